view_pose_scheduler: RTL

- Frame-synchronous pose controller that sits between game/physics logic and forward_view.
- Accepts new kart poses over a valid/ready handshake into a one-entry shadow buffer.
- Commits the buffered pose only at the start of vertical blanking, so forward_view never sees a parameter change mid-frame.
- Slew-limits the camera heading toward the commanded heading by at most MAX_STEP degrees per frame, wrapping at 360.

---
 rtl/view_pose_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/view_pose_scheduler.sv
// Frame-synchronous pose scheduler: buffers one pose and commits it at the start of vertical blanking,
// slew-limiting the heading. Optional macro VIEW_POSE_OVERWRITE_EN lets a newer pose replace a pending one.
module view_pose_scheduler #(
  parameter int V_ACTIVE = 720,
  parameter int MAX_STEP = 6,
  parameter int INIT_DIR = 90
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        pose_valid_in,
  output logic        pose_ready_out,
  input  logic [8:0]  pose_dir_in,
  input  logic [10:0] pose_px_in,
  input  logic [10:0] pose_py_in,
  input  logic [10:0] pose_ox_in,
  input  logic [10:0] pose_oy_in,
  output logic [8:0]  direction_out,
  output logic [10:0] player_x_out,
  output logic [10:0] player_y_out,
  output logic [10:0] opponent_x_out,
  output logic [10:0] opponent_y_out,
  output logic        commit_out,
  output logic [15:0] frame_count_out,
  output logic        state_dbg_out
);

  // Handshake: a pose transfers on any clock edge where pose_valid_in and
  // pose_ready_out are both high; the producer holds its fields stable until then.

  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] STEP_MAX = 10'(MAX_STEP);
  localparam logic [8:0] DIR_INIT = 9'(INIT_DIR);
  localparam logic [9:0] FULL     = 10'd360;
  localparam logic [9:0] HALF     = 10'd180;

  typedef enum logic {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [8:0]  sh_dir;
  logic [10:0] sh_px, sh_py, sh_ox, sh_oy;
  logic [8:0]  tgt_dir;

  logic        boundary;
  logic        accept;
  logic [8:0]  dir_norm;

  logic [9:0]  eff_tgt;
  logic [9:0]  cur;
  logic [9:0]  diff_raw;
  logic [9:0]  diff;
  logic [9:0]  back;
  logic [9:0]  step;
  logic [9:0]  sum;
  logic [9:0]  dir_next;

  assign boundary = (hcount_in == 11'd0) && (vcount_in == V_ACT);
  assign accept   = pose_valid_in && pose_ready_out;
  assign dir_norm = (pose_dir_in >= 9'd360) ? (pose_dir_in - 9'd360) : pose_dir_in;
  assign state_dbg_out = (state_q == PENDING);

  always_comb begin
    state_d        = state_q;
    pose_ready_out = 1'b0;
`ifdef VIEW_POSE_OVERWRITE_EN
    pose_ready_out = !rst_in;
`else
    pose_ready_out = (state_q == EMPTY);
`endif
    case (state_q)
      EMPTY: begin
        if (accept) state_d = PENDING;
      end
      PENDING: begin
        // Only reachable with overwrite enabled: the new pose stays pending.
        if (boundary) state_d = accept ? PENDING : EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // A pending pose's heading drives this commit's slew step; otherwise the held target does.
  always_comb begin
    eff_tgt  = (state_q == PENDING) ? {1'b0, sh_dir} : {1'b0, tgt_dir};
    cur      = {1'b0, direction_out};
    diff_raw = eff_tgt + FULL - cur;
    diff     = (diff_raw >= FULL) ? (diff_raw - FULL) : diff_raw;
    back     = FULL - diff;
    step     = 10'd0;
    sum      = 10'd0;
    dir_next = cur;
    if (diff == 10'd0) begin
      dir_next = cur;
    end else if (diff <= HALF) begin
      step     = (diff < STEP_MAX) ? diff : STEP_MAX;
      sum      = cur + step;
      dir_next = (sum >= FULL) ? (sum - FULL) : sum;
    end else begin
      step     = (back < STEP_MAX) ? back : STEP_MAX;
      dir_next = (cur >= step) ? (cur - step) : (cur + FULL - step);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= EMPTY;
      sh_dir          <= DIR_INIT;
      sh_px           <= 11'd0;
      sh_py           <= 11'd0;
      sh_ox           <= 11'd0;
      sh_oy           <= 11'd0;
      tgt_dir         <= DIR_INIT;
      direction_out   <= DIR_INIT;
      player_x_out    <= 11'd0;
      player_y_out    <= 11'd0;
      opponent_x_out  <= 11'd0;
      opponent_y_out  <= 11'd0;
      commit_out      <= 1'b0;
      frame_count_out <= 16'd0;
    end else begin
      state_q    <= state_d;
      commit_out <= boundary;
      if (accept) begin
        sh_dir <= dir_norm;
        sh_px  <= pose_px_in;
        sh_py  <= pose_py_in;
        sh_ox  <= pose_ox_in;
        sh_oy  <= pose_oy_in;
      end
      if (boundary) begin
        frame_count_out <= frame_count_out + 16'd1;
        direction_out   <= dir_next[8:0];
        if (state_q == PENDING) begin
          tgt_dir        <= sh_dir;
          player_x_out   <= sh_px;
          player_y_out   <= sh_py;
          opponent_x_out <= sh_ox;
          opponent_y_out <= sh_oy;
        end
      end
    end
  end

endmodule
